// File: rtl/interp_line_feeder.sv
// Tile line feeder: walks a BLK x BLK tile row- or column-wise with edge replication.
// Optional stall counter output enabled by defining FEEDER_STALL_CNT_EN.
module interp_line_feeder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int BLK    = 16,
   parameter int PRE    = 8,
   parameter int POST   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              ready,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pix_out,
   output logic              pix_valid,
   output logic              cap_valid,
   output logic [7:0]        cap_index,
   output logic              busy,
   output logic              done
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]       stall_count
`endif
);

   localparam int BEATS = PRE + BLK + POST;
   localparam int BW    = $clog2(BEATS + 1);
   localparam int LW    = $clog2(BLK + 1);

   typedef enum logic [1:0] {IDLE, FETCH, BEAT, DONE} state_t;

   state_t            state;
   logic [BW-1:0]     beat;
   logic [LW-1:0]     line;
   logic              mode_q;
   logic [ADDR_W-1:0] base_q;
   logic              busy_q;
   logic              valid_q;
   logic              done_q;

   logic              last_beat;
   logic              rd_win;
   logic              cap_win;
   logic [LW-1:0]     rd_elem;
   logic [LW-1:0]     cap_elem;

   function automatic logic [31:0] tile_idx(
      input logic [LW-1:0] l,
      input logic [LW-1:0] e,
      input logic          m
   );
      if (m)
         return 32'(e) * BLK + 32'(l);
      else
         return 32'(l) * BLK + 32'(e);
   endfunction

   assign last_beat = (beat == BW'(BEATS - 1));
   assign rd_win    = (beat >= BW'(PRE)) && (beat <= BW'(PRE + BLK - 2));
   assign cap_win   = (beat >= BW'(PRE + POST));
   // Element k is requested one beat early so it is on rd_data at beat PRE+k.
   assign rd_elem   = (state == FETCH) ? '0
                                       : LW'(beat - BW'(PRE) + BW'(1));
   assign cap_elem  = LW'(beat - BW'(PRE + POST));

   always_comb begin
      rd_en     = (state == FETCH) || ((state == BEAT) && ready && rd_win);
      rd_addr   = '0;
      if (rd_en)
         rd_addr = base_q + ADDR_W'(tile_idx(line, rd_elem, mode_q));
      pix_valid = valid_q;
      pix_out   = valid_q ? rd_data : '0;
      cap_valid = valid_q && ready && cap_win;
      cap_index = '0;
      if (cap_valid)
         cap_index = 8'(tile_idx(line, cap_elem, mode_q));
      busy      = busy_q;
      done      = done_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         beat    <= '0;
         line    <= '0;
         mode_q  <= 1'b0;
         base_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  base_q <= base_addr;
                  line   <= '0;
                  busy_q <= 1'b1;
                  state  <= FETCH;
               end
            end
            FETCH: begin
               beat    <= '0;
               valid_q <= 1'b1;
               state   <= BEAT;
            end
            BEAT: begin
               if (ready) begin
                  if (last_beat) begin
                     valid_q <= 1'b0;
                     if (line == LW'(BLK - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                     end else begin
                        line  <= line + 1'b1;
                        state <= FETCH;
                     end
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FEEDER_STALL_CNT_EN
   always_ff @(posedge clock) begin
      if (reset)
         stall_count <= '0;
      else if ((state == IDLE) && start)
         stall_count <= '0;
      else if ((state == BEAT) && !ready && (stall_count != '1))
         stall_count <= stall_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_interp_line_feeder.sv
// Scoreboard bench for interp_line_feeder against a tile-walk reference model.
// Build with FEEDER_STALL_CNT_EN defined to also check stall_count.
module tb_interp_line_feeder;

   localparam int DW       = 32;
   localparam int AW       = 32;
   localparam int BLK      = 16;
   localparam int PRE      = 8;
   localparam int POST     = 5;
   localparam int BEATS    = PRE + BLK + POST;
   localparam int PASS_CYC = 481;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [AW-1:0] base_addr;
   logic          ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] pix_out;
   logic          pix_valid;
   logic          cap_valid;
   logic [7:0]    cap_index;
   logic          busy;
   logic          done;
`ifdef FEEDER_STALL_CNT_EN
   logic [31:0]   stall_count;
`endif

   always #5 clock = ~clock;

   interp_line_feeder #(
      .DATA_W(DW), .ADDR_W(AW), .BLK(BLK), .PRE(PRE), .POST(POST)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .mode(mode),
      .base_addr(base_addr),
      .ready(ready),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .pix_out(pix_out),
      .pix_valid(pix_valid),
      .cap_valid(cap_valid),
      .cap_index(cap_index),
      .busy(busy),
      .done(done)
`ifdef FEEDER_STALL_CNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // synchronous-read memory: data appears the cycle after rd_en and holds
   always @(posedge clock)
      if (rd_en) rd_data <= memf(rd_addr);

   function automatic int idx(input int l, input int e, input logic m);
      return m ? e * BLK + l : l * BLK + e;
   endfunction

   logic [AW-1:0] q_addr[$];
   logic [DW-1:0] q_pix[$];
   logic [7:0]    q_cap[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit done_seen = 1'b0;
   int done_cyc = 0;
   int start_cyc = 0;
   int stalls_seen = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Whole-pass expectation: every read, every beat's pixel, every capture.
   task automatic model(input logic [AW-1:0] base, input logic m);
      for (int l = 0; l < BLK; l++) begin
         for (int e = 0; e < BLK; e++)
            q_addr.push_back(base + AW'(idx(l, e, m)));
         for (int b = 0; b < BEATS; b++) begin
            int el;
            el = b - PRE;
            if (el < 0) el = 0;
            if (el > BLK - 1) el = BLK - 1;
            q_pix.push_back(memf(base + AW'(idx(l, el, m))));
         end
         for (int e = 0; e < BLK; e++)
            q_cap.push_back(8'(idx(l, e, m)));
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (rd_en) begin
            if (q_addr.size() == 0) chk("rd_unexpected", rd_en, 0);
            else chk("rd_addr", rd_addr, q_addr.pop_front());
         end
         if (pix_valid) begin
            if (q_pix.size() == 0) chk("pix_unexpected", pix_valid, 0);
            else if (ready) chk("pix_out", pix_out, q_pix.pop_front());
            else begin
               chk("pix_hold", pix_out, q_pix[0]);
               chk("stall_rd_en", rd_en, 0);
               chk("stall_cap", cap_valid, 0);
               stalls_seen++;
            end
         end
         if (cap_valid) begin
            if (q_cap.size() == 0) chk("cap_unexpected", cap_valid, 0);
            else chk("cap_index", cap_index, q_cap.pop_front());
         end
         if (!busy && !pix_valid)
            chk("idle_zero", {rd_en, cap_valid, pix_out, cap_index}, 0);
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic begin_pass(input logic [AW-1:0] base, input logic m,
                             input bit hold);
      model(base, m);
      base_addr   = base;
      mode        = m;
      start       = 1'b1;
      start_cyc   = cyc;
      stalls_seen = 0;
      done_seen   = 1'b0;
      tick();
      start = hold;
   endtask

   task automatic wait_pass(input bit rnd, input int stall_at);
      int k;
      int rel;
      int exp_st;
      k = 0;
      while (!done_seen && k < 3000) begin
         rel = cyc - start_cyc;
         if (rnd)
            ready = ($urandom_range(0, 3) != 0);
         else
            ready = !(stall_at >= 0 && rel >= stall_at && rel < stall_at + 3);
         tick();
         k++;
      end
      ready = 1'b1;
      chk("done_seen", done_seen, 1);
      exp_st = rnd ? stalls_seen : (stall_at >= 0 ? 3 : 0);
      chk("done_cycle", done_cyc - start_cyc, PASS_CYC + exp_st);
      chk("queues_drained", q_addr.size() + q_pix.size() + q_cap.size(), 0);
`ifdef FEEDER_STALL_CNT_EN
      chk("stall_count", stall_count, exp_st);
`endif
      @(negedge clock);
      chk("done_pulse", {done, busy}, 0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b1;
      mode      = 1'b0;
      base_addr = '0;
      ready     = 1'b1;
      repeat (3) tick();
      @(negedge clock);
      chk("reset_busy", busy, 0);
      chk("reset_outs", {rd_en, pix_valid, cap_valid, done}, 0);
      tick();
      start = 1'b0;
      reset = 1'b0;
      tick();
      mon_en = 1'b1;

      begin_pass(32'h0000_0100, 1'b0, 1'b0);
      wait_pass(1'b0, -1);

      begin_pass(32'h0000_0000, 1'b1, 1'b0);
      wait_pass(1'b0, -1);

      // beat 10 of line 0 falls in relative cycle 12
      begin_pass(32'h0000_0040, 1'b0, 1'b0);
      wait_pass(1'b0, 12);

      begin_pass(32'hFFFF_FFF0, 1'b0, 1'b0);
      wait_pass(1'b0, -1);

      for (int r = 0; r < 2; r++) begin
         begin_pass($urandom, 1'($urandom_range(0, 1)), 1'b0);
         wait_pass(1'b1, -1);
      end

      // start held high: exactly one restart, from IDLE after done
      begin_pass(32'h0000_0200, 1'b1, 1'b1);
      wait_pass(1'b0, -1);
      model(32'h0000_0300, 1'b0);
      base_addr   = 32'h0000_0300;
      mode        = 1'b0;
      start_cyc   = cyc;
      stalls_seen = 0;
      done_seen   = 1'b0;
      tick();
      start = 1'b0;
      @(negedge clock);
      chk("restart_busy", busy, 1);
      wait_pass(1'b0, -1);

      // reset at line 5 beat 12
      begin_pass(32'h0000_0500, 1'b0, 1'b0);
      while (cyc - start_cyc < 2 + 5 * 30 + 12) tick();
      mon_en = 1'b0;
      reset  = 1'b1;
      tick();
      @(negedge clock);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_pix_valid", pix_valid, 0);
      chk("rst_mid_rd_en", rd_en, 0);
      tick();
      reset = 1'b0;
      q_addr.delete();
      q_pix.delete();
      q_cap.delete();
      tick();
      mon_en = 1'b1;
      begin_pass(32'h0000_0500, 1'b1, 1'b0);
      wait_pass(1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
